// File: rtl/elementwise_div_seq.sv
// rtl/elementwise_div_seq.sv - four-element sequential restoring divider
// One element at a time: LOAD, 2N shift-subtract ITER cycles, STORE; DONE pulses once.
module elementwise_div_seq #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*2*N-1:0]  a,
  input  logic [4*N-1:0]    b,
  output logic [4*2*N-1:0]  quotient,
  output logic [4*N-1:0]    remainder,
  output logic [3:0]        div_zero,
  output logic              busy,
  output logic              pulse_seq,
  output logic [CW-1:0]     cycle_count_seq
);

  localparam int DW = 2 * N;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_STORE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [4*DW-1:0]     a_q, a_d;
  logic [4*N-1:0]      b_q, b_d;
  logic [1:0]          idx_q, idx_d;
  logic [IW-1:0]       iter_q, iter_d;
  logic [N:0]          rem_q, rem_d;
  logic [DW-1:0]       dvd_q, dvd_d;
  logic [DW-1:0]       quo_q, quo_d;
  logic [4*DW-1:0]     quotient_q, quotient_d;
  logic [4*N-1:0]      remainder_q, remainder_d;
  logic [3:0]          div_zero_q, div_zero_d;
  logic [CW-1:0]       count_q, count_d;

  logic [DW-1:0]       cur_a;
  logic [N-1:0]        cur_b;
  logic [N:0]          r_shift;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    iter_d      = iter_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    count_d     = count_q;

    cur_a   = a_q[idx_q*DW +: DW];
    cur_b   = b_q[idx_q*N +: N];
    r_shift = {rem_q[N-1:0], dvd_q[DW-1]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        rem_d   = '0;
        dvd_d   = cur_a;
        quo_d   = '0;
        iter_d  = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        dvd_d  = dvd_q << 1;
        iter_d = iter_q + IW'(1);
        if (r_shift >= {1'b0, cur_b}) begin
          rem_d = r_shift - {1'b0, cur_b};
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = r_shift;
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        if (iter_q == IW'(DW - 1)) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        // Zero divisor is stored explicitly so the result does not depend on loop artefacts.
        if (cur_b == '0) begin
          quotient_d[idx_q*DW +: DW] = '1;
          remainder_d[idx_q*N +: N]  = cur_a[N-1:0];
          div_zero_d[idx_q]          = 1'b1;
        end else begin
          quotient_d[idx_q*DW +: DW] = quo_q;
          remainder_d[idx_q*N +: N]  = rem_q[N-1:0];
          div_zero_d[idx_q]          = 1'b0;
        end
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == 2'd3) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_LOAD || state_q == S_ITER || state_q == S_STORE) && count_q != '1) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      iter_q      <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      iter_q      <= iter_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      count_q     <= count_d;
    end
  end

  assign quotient        = quotient_q;
  assign remainder       = remainder_q;
  assign div_zero        = div_zero_q;
  assign busy            = (state_q != S_IDLE);
  assign pulse_seq       = (state_q == S_DONE);
  assign cycle_count_seq = count_q;

endmodule

// File: tb/tb_elementwise_div_seq.sv
// tb/tb_elementwise_div_seq.sv - randomized self-checking bench for elementwise_div_seq
// Drives and samples on the falling edge; a second instance with CW=6 checks saturation.
module tb_elementwise_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [31:0] b;

  logic [63:0] quotient, quotient_s;
  logic [31:0] remainder, remainder_s;
  logic [3:0]  div_zero, div_zero_s;
  logic        busy, busy_s;
  logic        pulse_seq, pulse_s;
  logic [7:0]  cycle_count_seq;
  logic [5:0]  count_s;

  int vectors;
  int miscompares;
  logic [63:0] exp_q_prev;

  elementwise_div_seq #(.N(8), .CW(8)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .a               (a),
    .b               (b),
    .quotient        (quotient),
    .remainder       (remainder),
    .div_zero        (div_zero),
    .busy            (busy),
    .pulse_seq       (pulse_seq),
    .cycle_count_seq (cycle_count_seq)
  );

  elementwise_div_seq #(.N(8), .CW(6)) u_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .a               (a),
    .b               (b),
    .quotient        (quotient_s),
    .remainder       (remainder_s),
    .div_zero        (div_zero_s),
    .busy            (busy_s),
    .pulse_seq       (pulse_s),
    .cycle_count_seq (count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [63:0] av, input logic [31:0] bv,
                       output logic [63:0] q, output logic [31:0] r, output logic [3:0] dz);
    int unsigned ai;
    int unsigned bi;
    q  = '0;
    r  = '0;
    dz = '0;
    for (int i = 0; i < 4; i++) begin
      ai = av[i*16 +: 16];
      bi = bv[i*8 +: 8];
      if (bi == 0) begin
        q[i*16 +: 16] = 16'hFFFF;
        r[i*8 +: 8]   = av[i*16 +: 8];
        dz[i]         = 1'b1;
      end else begin
        q[i*16 +: 16] = 16'(ai / bi);
        r[i*8 +: 8]   = 8'(ai % bi);
      end
    end
  endtask

  // Called on a falling edge while the DUT is idle; returns on a falling edge in IDLE.
  task automatic run_op(input logic [63:0] av, input logic [31:0] bv, input bit disturb);
    logic [63:0] eq;
    logic [31:0] er;
    logic [3:0]  edz;
    int          e;
    int          extra;
    bit          busy_ok;
    model(av, bv, eq, er, edz);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    e       = 0;
    busy_ok = 1'b1;
    while (!pulse_seq && e < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (e == 17) check("hold_prev", quotient, exp_q_prev);
      if (e == 18) check("elem0_store", {48'd0, quotient[15:0]}, {48'd0, eq[15:0]});
      if (disturb && e == 30) begin
        start = 1'b1;
        a     = ~av;
        b     = bv + 32'h01010101;
      end
      if (disturb && e == 31) begin
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = $urandom;
      end
      @(negedge clk);
      e++;
    end
    check("latency", e, 72);
    check("busy_held", busy_ok, 1);
    check("count", cycle_count_seq, 72);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, edz);
    check("sat_pulse", pulse_s, 1);
    check("sat_count", count_s, 63);
    check("sat_quotient", quotient_s, eq);
    @(negedge clk);
    check("pulse_width", pulse_seq, 0);
    check("idle_after", busy, 0);
    if (disturb) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (pulse_seq || busy) extra++;
      end
      check("no_extra_op", extra, 0);
    end
    exp_q_prev = eq;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_q_prev  = '0;
    rst_n       = 1'b0;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", pulse_seq, 0);
    check("rst_count", cycle_count_seq, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op({16'd32, 16'd18, 16'd8, 16'd2}, {8'd8, 8'd6, 8'd4, 8'd2}, 1'b0);
    check("basic_const", quotient, {16'd4, 16'd3, 16'd2, 16'd1});
    run_op({16'd0, 16'd255, 16'd65535, 16'd17}, {8'd7, 8'd255, 8'd1, 8'd5}, 1'b0);
    check("extreme_const_r", remainder, {8'd0, 8'd0, 8'd0, 8'd2});
    run_op({16'd9, 16'd9, 16'd300, 16'd100}, {8'd3, 8'd0, 8'd7, 8'd0}, 1'b0);
    check("dz_const", div_zero, 4'b0101);
    run_op({$urandom, $urandom}, $urandom, 1'b1);

    a     = {$urandom, $urandom};
    b     = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_zero", div_zero, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", cycle_count_seq, 0);
    check("midrst_sat_busy", busy_s, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    exp_q_prev = '0;
    @(negedge clk);
    run_op({16'd1000, 16'd77, 16'd5, 16'd60000}, {8'd3, 8'd9, 8'd0, 8'd200}, 1'b0);

    for (int k = 0; k < 15; k++) begin
      logic [31:0] bv;
      bv = $urandom;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) bv[i*8 +: 8] = 8'd0;
        else if ($urandom_range(0, 2) == 0) bv[i*8 +: 8] = 8'($urandom_range(1, 4));
      end
      run_op({$urandom, $urandom}, bv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elementwise_div_seq.md
# elementwise_div_seq

Sequential elementwise divider: the inverse of the elementwise multiplier. It takes four 2N-bit dividends (typically the multiplier's products) and four N-bit divisors. It computes each quotient and remainder with a restoring shift-subtract loop, one element at a time. It reports completion with a one-cycle `pulse_seq`, and reports the cycles spent in `cycle_count_seq` for comparison against the multiplier.

## Interface
- `N`, 8, divisor width; dividend and quotient width is 2N
- `CW`, 8, width of `cycle_count_seq`
- `clk` input 1: rising-edge clock
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: request a division of all four elements; sampled only in IDLE
- `a` input 4×2N (packed; element i at `[i*2N +: 2N]`): dividends
- `b` input 4×N (packed; element i at `[i*N +: N]`): divisors
- `quotient` output 4×2N: quotients, element i at `[i*2N +: 2N]`
- `remainder` output 4×N: remainders, element i at `[i*N +: N]`
- `div_zero` output 4: bit i is set when `b[i]` was 0 in the last operation
- `busy` output 1: high whenever the state is not IDLE
- `pulse_seq` output 1: high for exactly one cycle when all four results are valid
- `cycle_count_seq` output CW: cycles spent in LOAD/ITER/STORE for the last operation

## Operation
- Reset value of every output is 0, including `quotient`, `remainder`, `div_zero`, `busy`, `pulse_seq` and `cycle_count_seq`. The FSM resets to IDLE.
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → ITER.
  - ITER → STORE after 2N iterations.
  - STORE → LOAD if the element index is below 3, otherwise → DONE.
  - DONE → IDLE.
- On leaving IDLE:
  - `a` and `b` are captured into internal registers; later input changes have no effect.
  - Element index is set to 0.
  - `cycle_count_seq` is cleared to 0.
  - `quotient`, `remainder` and `div_zero` are not cleared at this point.
- LOAD: partial remainder R (N+1 bits) is set to 0. The dividend shift register is loaded with the current element's dividend.
- ITER, one iteration per cycle:
  - R' = {R[N-1:0], dividend MSB}, and the dividend register shifts left by one.
  - If R' ≥ {1'b0, divisor}: R = R' − divisor, and a 1 is shifted into the quotient LSB.
  - Otherwise: R = R', and a 0 is shifted into the quotient LSB.
- STORE: the current element's slot in `quotient`, `remainder` (R[N-1:0]) and `div_zero` is written, and the element index increments.
- Divide-by-zero:
  - The fixed latency is kept: ITER still runs 2N cycles.
  - The stored quotient is all ones (2^(2N)−1).
  - The stored remainder is the dividend's low N bits.
  - The `div_zero` bit is set.
  - No other element is affected.
- DONE: `pulse_seq` = 1 for this cycle only. Results remain stable until STORE of element 0 in the next operation.
- `cycle_count_seq`:
  - Increments by 1 on every cycle spent in LOAD, ITER or STORE.
  - Saturates at 2^CW − 1.
  - Holds its value in DONE and IDLE.
- `start` is ignored while `busy` is high.
- `start` held high through DONE → IDLE starts a new operation on the next IDLE cycle.
- If `rst_n` is asserted mid-operation, all state and outputs clear immediately. Partial results are discarded.

## Timing
- Per element: 1 (LOAD) + 2N (ITER) + 1 (STORE) = 2N+2 cycles.
- Total per operation: 4(2N+2) cycles. For N=8 this is 72.
- `start` sampled high at edge 0 → `busy` is high after edge 0. `pulse_seq` is high in the cycle following edge 72 (N=8), and `busy` stays high through DONE.
- `cycle_count_seq` reads 72 while `pulse_seq` is high (N=8, CW=8).
- Element i's outputs update at the STORE edge of element i: edge (i+1)(2N+2) after start.
- Earliest restart: `start` high in the cycle after DONE. This gives a back-to-back period of 4(2N+2)+2 cycles.

## Test plan
- Basic inverse case: a = {2,8,18,32}, b = {2,4,6,8}, one-cycle `start` → `quotient` = {1,2,3,4}, `remainder` = {0,0,0,0}, `div_zero` = 0. `pulse_seq` fires exactly 72 cycles after the start edge, and `cycle_count_seq` = 72.
- Remainders and extremes: a = {17,65535,255,0}, b = {5,1,255,7} → `quotient` = {3,65535,1,0}, `remainder` = {2,0,0,0}.
- Divide-by-zero: a = {100,300,9,9}, b = {0,7,0,3} → `quotient` = {65535,42,65535,3}, `remainder` = {100,6,9,0}, `div_zero` = 4'b0101. Latency is still 72.
- Busy protection: pulse `start` again at cycle 30 with different a/b, and change a/b mid-operation → results match the first operand set. Exactly one `pulse_seq` is produced, and `busy` is continuously high until DONE.
- Reset mid-operation: drop `rst_n` at cycle 40 → all outputs read 0 immediately and the FSM is in IDLE. A fresh `start` then completes normally with `cycle_count_seq` = 72.
- Saturation: set CW=6 → `cycle_count_seq` = 63 at `pulse_seq`, and the quotients are still correct.
